prt_dptx_trn_gen: RTL and testbench

Link-clock-domain training and idle pattern generator for the DP TX path. It produces per-lane K/D symbol streams (TPS1, TPS2, scrambled idle with periodic SR) that the TX PHY 8b/10b-encodes. It drives the same symbol layout that the DP RX link layer consumes, so RX clock recovery and channel equalisation can lock. It is configured by the TX policy maker through static control bits synchronised into the link domain.

---
 rtl/prt_dptx_pkg.sv | 35 +++
 rtl/prt_dp_scrm.sv | 25 ++
 rtl/prt_dptx_trn_gen.sv | 149 ++++++++++++++
 tb/tb_prt_dptx_trn_gen.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/prt_dptx_pkg.sv
// Shared symbol constants and pattern types for the DP TX training generator.
// Symbols are 9 bits: bit 8 = K flag, bits 7:0 = code byte.
package prt_dptx_pkg;

    typedef enum logic [1:0] {
        TPS_OFF  = 2'd0,
        TPS1     = 2'd1,
        TPS2     = 2'd2,
        TPS_IDLE = 2'd3
    } tps_t;

    localparam logic [8:0] SYM_D0_0  = 9'h000;
    localparam logic [8:0] SYM_D10_2 = 9'h04A;
    localparam logic [8:0] SYM_D11_6 = 9'h0CB;
    localparam logic [8:0] SYM_K28_5 = 9'h1BC;
    localparam logic [8:0] SYM_SR    = 9'h11C;

    localparam int TPS2_LEN = 10;

    // Element 0 is the rightmost entry: K28.5, D11.6, K28.5, D11.6, D10.2 x6.
    localparam logic [TPS2_LEN-1:0][8:0] TPS2_SEQ = {
        SYM_D10_2, SYM_D10_2, SYM_D10_2,
        SYM_D10_2, SYM_D10_2, SYM_D10_2,
        SYM_D11_6, SYM_K28_5, SYM_D11_6, SYM_K28_5
    };

    // ph may exceed 9 by at most one sequence length when a clock
    // straddles the wrap point.
    function automatic logic [8:0] tps2_sym(input logic [4:0] ph);
        logic [4:0] p;
        p = (ph >= 5'(TPS2_LEN)) ? ph - 5'(TPS2_LEN) : ph;
        return TPS2_SEQ[p[3:0]];
    endfunction

endpackage

// File: rtl/prt_dp_scrm.sv
// One-symbol DP scrambler step, x^16+x^5+x^4+x^3+1 Galois form, LSB first.
// Ports: lfsr_i/dat_i = state and byte in; lfsr_o/dat_o = state and byte out.
module prt_dp_scrm (
    input  logic [15:0] lfsr_i,
    input  logic [7:0]  dat_i,
    output logic [15:0] lfsr_o,
    output logic [7:0]  dat_o
);

    logic [15:0] l;
    logic        fb;

    always_comb begin
        l     = lfsr_i;
        fb    = 1'b0;
        dat_o = '0;
        for (int b = 0; b < 8; b++) begin
            fb       = l[15];
            dat_o[b] = dat_i[b] ^ fb;
            l        = {l[14:0], fb} ^ {10'b0, fb, fb, fb, 3'b0};
        end
        lfsr_o = l;
    end

endmodule

// File: rtl/prt_dptx_trn_gen.sv
// DP TX link-domain training / idle symbol generator (TPS1, TPS2, scrambled idle).
// Ports: LNK_CLK_IN/LNK_RST_IN clock and sync reset; CFG_* static config;
//        LNK_DAT_OUT per-lane 9-bit symbols; LNK_SOP_OUT pattern-start pulse.
module prt_dptx_trn_gen
    import prt_dptx_pkg::*;
#(
    parameter int P_LANES       = 4,
    parameter int P_SPL         = 2,
    parameter int P_SR_INTERVAL = 512
) (
    input  logic                         LNK_CLK_IN,
    input  logic                         LNK_RST_IN,
    input  logic                         CFG_EN_IN,
    input  logic [1:0]                   CFG_TPS_IN,
    input  logic [1:0]                   CFG_LANES_IN,
    output logic [P_LANES*P_SPL*9-1:0]   LNK_DAT_OUT,
    output logic                         LNK_SOP_OUT
);

    localparam int PH_W = $clog2(P_SR_INTERVAL);

    tps_t                       tps_in;
    tps_t                       tps_q;
    logic                       en_q;
    logic [PH_W-1:0]            ph_q, ph_d, ph_base;
    logic [15:0]                lfsr_q, lfsr_d, lfsr_base;
    logic [P_LANES*P_SPL*9-1:0] dat_q, dat_d;
    logic                       sop_q, sop_d;
    logic                       restart;
    logic [2:0]                 n_act;

    logic [P_SPL-1:0]           is_sr;
    logic [15:0]                lfsr_c   [P_SPL+1];
    logic [15:0]                scr_lfsr [P_SPL];
    logic [7:0]                 scr_dat  [P_SPL];
    logic [8:0]                 sym      [P_SPL];

    assign tps_in = tps_t'(CFG_TPS_IN);

    // A new pattern (or a fresh enable) always starts from phase 0 with a
    // seeded scrambler, so no partial sequence is ever spliced in.
    assign restart   = !en_q || (tps_in != tps_q);
    assign ph_base   = restart ? '0 : ph_q;
    assign lfsr_base = restart ? 16'hFFFF : lfsr_q;

    assign lfsr_c[0] = lfsr_base;

    for (genvar j = 0; j < P_SPL; j++) begin : g_scr
        // The interval is a multiple of P_SPL, so SR can only land on symbol 0.
        if (j == 0) begin : g_sr0
            assign is_sr[j] = (ph_base == '0);
        end else begin : g_srn
            assign is_sr[j] = 1'b0;
        end

        prt_dp_scrm u_scrm (
            .lfsr_i (lfsr_c[j]),
            .dat_i  (8'h00),
            .lfsr_o (scr_lfsr[j]),
            .dat_o  (scr_dat[j])
        );

        // SR reseeds the scrambler for the symbol that follows it.
        assign lfsr_c[j+1] = is_sr[j] ? 16'hFFFF : scr_lfsr[j];
    end

    always_comb begin
        for (int j = 0; j < P_SPL; j++) begin
            sym[j] = SYM_D0_0;
            unique case (tps_in)
                TPS_OFF:  sym[j] = SYM_D0_0;
                TPS1:     sym[j] = SYM_D10_2;
                TPS2:     sym[j] = tps2_sym(5'(ph_base[3:0]) + 5'(j));
                TPS_IDLE: sym[j] = is_sr[j] ? SYM_SR : {1'b0, scr_dat[j]};
            endcase
        end
    end

    always_comb begin
        case (CFG_LANES_IN)
            2'd0:    n_act = 3'd1;
            2'd1:    n_act = 3'd2;
            default: n_act = 3'd4;
        endcase
    end

    always_comb begin
        dat_d = '0;
        for (int i = 0; i < P_LANES; i++) begin
            for (int j = 0; j < P_SPL; j++) begin
                if (CFG_EN_IN && (3'(i) < n_act)) begin
                    dat_d[(i*P_SPL+j)*9 +: 9] = sym[j];
                end
            end
        end
    end

    always_comb begin
        ph_d   = '0;
        lfsr_d = 16'hFFFF;
        sop_d  = 1'b0;
        if (CFG_EN_IN) begin
            unique case (tps_in)
                TPS2: begin
                    sop_d = (ph_base == '0);
                    if (5'(ph_base[3:0]) + 5'(P_SPL) >= 5'(TPS2_LEN)) begin
                        ph_d = PH_W'(5'(ph_base[3:0]) + 5'(P_SPL) - 5'(TPS2_LEN));
                    end else begin
                        ph_d = PH_W'(5'(ph_base[3:0]) + 5'(P_SPL));
                    end
                end
                TPS_IDLE: begin
                    sop_d  = (ph_base == '0);
                    lfsr_d = lfsr_c[P_SPL];
                    if (ph_base == PH_W'(P_SR_INTERVAL - P_SPL)) begin
                        ph_d = '0;
                    end else begin
                        ph_d = ph_base + PH_W'(P_SPL);
                    end
                end
                TPS_OFF, TPS1: begin
                    ph_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge LNK_CLK_IN) begin
        if (LNK_RST_IN) begin
            en_q   <= 1'b0;
            tps_q  <= TPS_OFF;
            ph_q   <= '0;
            lfsr_q <= 16'hFFFF;
            dat_q  <= '0;
            sop_q  <= 1'b0;
        end else begin
            en_q   <= CFG_EN_IN;
            tps_q  <= tps_in;
            ph_q   <= ph_d;
            lfsr_q <= lfsr_d;
            dat_q  <= dat_d;
            sop_q  <= sop_d;
        end
    end

    assign LNK_DAT_OUT = dat_q;
    assign LNK_SOP_OUT = sop_q;

endmodule

// File: tb/tb_prt_dptx_trn_gen.sv
// Self-checking bench for prt_dptx_trn_gen (4 lanes, 2 symbols/clock, SR every 16).
// Symbol-stream reference model plus directed and random configuration steps.
module tb_prt_dptx_trn_gen;

    localparam int NL  = 4;
    localparam int SPL = 2;
    localparam int SRI = 16;
    localparam int DW  = NL * SPL * 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [1:0]    tps;
    logic [1:0]    lanes;
    logic [DW-1:0] dat;
    logic          sop;

    always #5 clk = ~clk;

    prt_dptx_trn_gen #(
        .P_LANES       (NL),
        .P_SPL         (SPL),
        .P_SR_INTERVAL (SRI)
    ) dut (
        .LNK_CLK_IN   (clk),
        .LNK_RST_IN   (rst),
        .CFG_EN_IN    (en),
        .CFG_TPS_IN   (tps),
        .CFG_LANES_IN (lanes),
        .LNK_DAT_OUT  (dat),
        .LNK_SOP_OUT  (sop)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: symbols emitted since the pattern last (re)started.
    bit            m_en;
    int            m_tps;
    int            m_cnt;
    logic [DW-1:0] e_dat;
    logic          e_sop;
    logic [7:0]    scr_bytes [SRI];
    logic [8:0]    tps2_tab  [10];

    task automatic chk(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] exp_sym(input int t, input int k);
        case (t)
            1:       return 9'h04A;
            2:       return tps2_tab[k % 10];
            3:       return (k % SRI == 0) ? 9'h11C
                                           : {1'b0, scr_bytes[(k % SRI) - 1]};
            default: return 9'h000;
        endcase
    endfunction

    task automatic model_step();
        e_dat = '0;
        e_sop = 1'b0;
        if (rst) begin
            m_en  = 1'b0;
            m_tps = 0;
            m_cnt = 0;
        end else if (!en) begin
            m_en  = 1'b0;
            m_tps = int'(tps);
            m_cnt = 0;
        end else begin
            int nact;
            if (!m_en || int'(tps) != m_tps) m_cnt = 0;
            nact = (lanes == 2'd0) ? 1 : (lanes == 2'd1) ? 2 : 4;
            for (int l = 0; l < NL; l++)
                if (l < nact)
                    for (int s = 0; s < SPL; s++)
                        e_dat[(l*SPL+s)*9 +: 9] = exp_sym(int'(tps), m_cnt + s);
            e_sop = (tps == 2'd2 && m_cnt % 10 == 0) ||
                    (tps == 2'd3 && m_cnt % SRI == 0);
            m_cnt += SPL;
            m_en  = 1'b1;
            m_tps = int'(tps);
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("dat", dat, e_dat);
        chk("sop", DW'(sop), DW'(e_sop));
    endtask

    initial begin
        logic [15:0] l;
        logic        fb;

        tps2_tab = '{9'h1BC, 9'h0CB, 9'h1BC, 9'h0CB, 9'h04A,
                     9'h04A, 9'h04A, 9'h04A, 9'h04A, 9'h04A};
        l = 16'hFFFF;
        for (int n = 0; n < SRI; n++) begin
            for (int b = 0; b < 8; b++) begin
                fb              = l[15];
                scr_bytes[n][b] = fb;
                l               = {l[14:0], fb} ^ (fb ? 16'h0038 : 16'h0000);
            end
        end

        rst = 1'b1; en = 1'b0; tps = 2'd0; lanes = 2'd0;
        cycle();
        cycle();

        rst = 1'b0; en = 1'b1; tps = 2'd1; lanes = 2'd1;
        repeat (4) cycle();

        tps = 2'd2; lanes = 2'd2;
        cycle();
        chk("tps2_first", DW'(dat[17:0]), DW'({9'h0CB, 9'h1BC}));
        chk("tps2_sop", DW'(sop), DW'(1'b1));
        repeat (11) cycle();

        tps = 2'd3;
        cycle();
        chk("idle_sr_ff", DW'(dat[17:0]), DW'({9'h0FF, 9'h11C}));
        cycle();
        chk("idle_17", DW'(dat[8:0]), DW'(9'h017));
        repeat (20) cycle();

        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        chk("rst_sr_ff", DW'(dat[17:0]), DW'({9'h0FF, 9'h11C}));
        repeat (5) cycle();

        tps = 2'd2;
        repeat (3) cycle();
        en = 1'b0;
        repeat (3) cycle();
        en = 1'b1;
        cycle();
        chk("reen_k285", DW'(dat[8:0]), DW'(9'h1BC));
        repeat (6) cycle();

        lanes = 2'd0; cycle(); cycle();
        lanes = 2'd3; cycle(); cycle();
        tps = 2'd0; repeat (3) cycle();

        repeat (400) begin
            rst   = ($urandom_range(0, 49) == 0);
            en    = ($urandom_range(0, 15) != 0);
            lanes = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) tps = 2'($urandom_range(0, 3));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
